// File: rtl/fp_divide64_iter.sv
// Iterative IEEE 754 binary64 divider: restoring radix-2 quotient, then normalize and round.
// One operation at a time behind a ld/done handshake; all state advances only while ce is high.
module fp_divide64_iter #(
  parameter int QBITS = 56,
  parameter int LAT   = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        ld,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [2:0]  rm,
  output logic [63:0] o,
  output logic        busy,
  output logic        done,
  output logic        inf,
  output logic        overflow,
  output logic        underflow,
  output logic        dbz,
  output logic        invalid
);

  if (QBITS != 56 || LAT != QBITS + 3) begin : g_cfg_check
    $error("fp_divide64_iter: datapath slicing assumes QBITS=56 and LAT=QBITS+3");
  end

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIV  = 3'd1;
  localparam logic [2:0] S_NORM = 3'd2;
  localparam logic [2:0] S_RND  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RUP = 3'd2;
  localparam logic [2:0] RM_RDN = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [62:0] MAX_FINITE = 63'h7FEF_FFFF_FFFF_FFFF;
  localparam logic [62:0] INF_MAG    = 63'h7FF0_0000_0000_0000;
  localparam logic [63:0] QNAN_DEF   = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] QUIET_BIT  = 64'h0008_0000_0000_0000;

  // Flag vector layout: {inf, overflow, underflow, dbz, invalid}
  logic [2:0]         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2:0]         rm_q, rm_d;
  logic               sign_q, sign_d;
  logic signed [12:0] exp_q, exp_d;
  logic [52:0]        mb_q, mb_d;
  logic [54:0]        rem_q, rem_d;
  logic [QBITS-1:0]   quo_q, quo_d;
  logic               sticky_q, sticky_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               spec_q, spec_d;
  logic [63:0]        spec_res_q, spec_res_d;
  logic [4:0]         spec_fl_q, spec_fl_d;
  logic [63:0]        o_q, o_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [4:0]         flags_q, flags_d;

  // Operand unpacking and classification; denormals count as zero.
  logic [10:0]        a_exp, b_exp;
  logic [51:0]        a_frac, b_frac;
  logic               a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic               sign_in;
  logic signed [12:0] exp_in;

  assign a_exp   = a[62:52];
  assign b_exp   = b[62:52];
  assign a_frac  = a[51:0];
  assign b_frac  = b[51:0];
  assign a_nan   = (&a_exp) && (|a_frac);
  assign b_nan   = (&b_exp) && (|b_frac);
  assign a_snan  = a_nan && !a_frac[51];
  assign b_snan  = b_nan && !b_frac[51];
  assign a_inf   = (&a_exp) && !(|a_frac);
  assign b_inf   = (&b_exp) && !(|b_frac);
  assign a_zero  = (a_exp == 11'd0);
  assign b_zero  = (b_exp == 11'd0);
  assign sign_in = a[63] ^ b[63];
  assign exp_in  = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 13'sd1023;

  logic        spec_hit;
  logic [63:0] spec_res;
  logic [4:0]  spec_fl;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    spec_hit = 1'b1;
    spec_res = 64'd0;
    spec_fl  = 5'd0;
    if (a_nan) begin
      spec_res   = a | QUIET_BIT;
      spec_fl[0] = a_snan;
    end else if (b_nan) begin
      spec_res   = b | QUIET_BIT;
      spec_fl[0] = b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res   = QNAN_DEF;
      spec_fl[0] = 1'b1;
    end else if (a_inf) begin
      spec_res   = {sign_in, INF_MAG};
      spec_fl[4] = 1'b1;
    end else if (b_zero) begin
      spec_res   = {sign_in, INF_MAG};
      spec_fl    = 5'b10010;
    end else if (a_zero || b_inf) begin
      spec_res   = {sign_in, 63'd0};
    end else begin
      spec_hit   = 1'b0;
    end
  end

  // Restoring division step: compare, conditionally subtract, shift.
  logic        q_bit;
  logic [54:0] rem_sub, rem_next;

  assign q_bit    = (rem_q >= {2'b00, mb_q});
  assign rem_sub  = q_bit ? (rem_q - {2'b00, mb_q}) : rem_q;
  assign rem_next = rem_sub << 1;

  logic [QBITS-1:0]   quo_n;
  logic signed [12:0] exp_n;

  assign quo_n = quo_q[QBITS-1] ? quo_q : {quo_q[QBITS-2:0], 1'b0};
  assign exp_n = quo_q[QBITS-1] ? exp_q : exp_q - 13'sd1;

  // Rounding: 53-bit significand, guard, round, sticky (sticky already folds in bit 0).
  logic [52:0]        mant;
  logic               lsb, g_bit, r_bit, any_lost, inc, to_inf, ovf_r;
  logic [53:0]        sum;
  logic signed [12:0] exp_r;
  logic [51:0]        frac_r;
  logic [63:0]        res_r;
  logic [4:0]         fl_r;

  assign mant     = quo_q[QBITS-1 -: 53];
  assign lsb      = quo_q[QBITS-53];
  assign g_bit    = quo_q[QBITS-54];
  assign r_bit    = quo_q[QBITS-55];
  assign any_lost = g_bit | r_bit | sticky_q;

  always_comb begin
    inc    = 1'b0;
    to_inf = 1'b1;
    case (rm_q)
      RM_RTZ: begin inc = 1'b0;                to_inf = 1'b0;    end
      RM_RUP: begin inc = !sign_q && any_lost; to_inf = !sign_q; end
      RM_RDN: begin inc = sign_q && any_lost;  to_inf = sign_q;  end
      RM_RMM: begin inc = g_bit;               to_inf = 1'b1;    end
      default: begin inc = g_bit && (lsb || r_bit || sticky_q); to_inf = 1'b1; end
    endcase
  end

  // A carry out of the significand leaves exactly 2^53, i.e. fraction zero at e+1.
  assign sum    = {1'b0, mant} + {53'd0, inc};
  assign exp_r  = sum[53] ? exp_q + 13'sd1 : exp_q;
  assign frac_r = sum[53] ? sum[52:1] : sum[51:0];
  assign ovf_r  = ovf_q || (exp_r >= 13'sd2047);

  always_comb begin
    res_r = {sign_q, exp_r[10:0], frac_r};
    fl_r  = 5'd0;
    if (spec_q) begin
      res_r = spec_res_q;
      fl_r  = spec_fl_q;
    end else if (ovf_r) begin
      res_r = to_inf ? {sign_q, INF_MAG} : {sign_q, MAX_FINITE};
      fl_r  = {to_inf, 1'b1, 3'b000};
    end else if (unf_q) begin
      res_r = {sign_q, 63'd0};
      fl_r  = 5'b00100;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rm_d       = rm_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mb_d       = mb_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    sticky_d   = sticky_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_fl_d  = spec_fl_q;
    o_d        = o_q;
    busy_d     = busy_q;
    done_d     = done_q;
    flags_d    = flags_q;
    case (state_q)
      S_IDLE: begin
        if (ld) begin
          state_d    = S_DIV;
          cnt_d      = 6'd0;
          rm_d       = rm;
          sign_d     = sign_in;
          exp_d      = exp_in;
          mb_d       = {1'b1, b_frac};
          rem_d      = {3'b001, a_frac};
          quo_d      = '0;
          sticky_d   = 1'b0;
          ovf_d      = 1'b0;
          unf_d      = 1'b0;
          spec_d     = spec_hit;
          spec_res_d = spec_res;
          spec_fl_d  = spec_fl;
          busy_d     = 1'b1;
          flags_d    = 5'd0;
        end
      end
      S_DIV: begin
        rem_d = rem_next;
        quo_d = {quo_q[QBITS-2:0], q_bit};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(QBITS - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        quo_d    = quo_n;
        exp_d    = exp_n;
        sticky_d = (|rem_q) | quo_n[0];
        ovf_d    = (exp_n >= 13'sd2047);
        unf_d    = (exp_n <= 13'sd0);
        state_d  = S_RND;
      end
      S_RND: begin
        o_d     = res_r;
        flags_d = fl_r;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments only; reset is asynchronous and clears every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      rm_q       <= 3'd0;
      sign_q     <= 1'b0;
      exp_q      <= 13'sd0;
      mb_q       <= 53'd0;
      rem_q      <= 55'd0;
      quo_q      <= '0;
      sticky_q   <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= 64'd0;
      spec_fl_q  <= 5'd0;
      o_q        <= 64'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      flags_q    <= 5'd0;
    end else if (ce) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rm_q       <= rm_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      mb_q       <= mb_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      sticky_q   <= sticky_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_fl_q  <= spec_fl_d;
      o_q        <= o_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      flags_q    <= flags_d;
    end
  end

  assign o         = o_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign inf       = flags_q[4];
  assign overflow  = flags_q[3];
  assign underflow = flags_q[2];
  assign dbz       = flags_q[1];
  assign invalid   = flags_q[0];

endmodule

// File: tb/tb_fp_divide64_iter.sv
// Directed self-checking bench for fp_divide64_iter: values, flags, latency, handshake corner cases.
module tb_fp_divide64_iter;

  logic        clk = 1'b0;
  logic        rst, ce, ld;
  logic [63:0] a, b;
  logic [2:0]  rm;
  logic [63:0] o;
  logic        busy, done, inf, overflow, underflow, dbz, invalid;

  int pass_cnt = 0;
  int total_cnt = 0;

  fp_divide64_iter dut (
    .clk(clk), .rst(rst), .ce(ce), .ld(ld), .a(a), .b(b), .rm(rm),
    .o(o), .busy(busy), .done(done), .inf(inf), .overflow(overflow),
    .underflow(underflow), .dbz(dbz), .invalid(invalid)
  );

  always #5 clk = ~clk;

  // Flag order {inf, overflow, underflow, dbz, invalid}
  function automatic logic [4:0] flags_now();
    return {inf, overflow, underflow, dbz, invalid};
  endfunction

  // Drives one operation; ld_at pulses a stray ld, stall_at drops ce for 5 cycles (0 = unused).
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb, input logic [2:0] trm,
                        input int ld_at, input int stall_at,
                        output logic [63:0] res, output logic [4:0] fl,
                        output int lat, output int bcnt);
    @(negedge clk);
    a = ta; b = tb; rm = trm; ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    lat = 1; bcnt = 0; res = 'x; fl = 'x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ce = !(stall_at > 0 && lat >= stall_at && lat < stall_at + 5);
      if (lat == ld_at) begin
        ld = 1'b1; a = 64'h4024_0000_0000_0000; b = 64'h3FF0_0000_0000_0000;
      end else begin
        ld = 1'b0;
      end
      if (busy) bcnt++;
      if (done) begin
        res = o; fl = flags_now();
        break;
      end
      @(posedge clk);
      lat++;
    end
    ce = 1'b1; ld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; ld = 1'b0; a = '0; b = '0; rm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (o !== 64'd0) $display("FAIL reset_o: got %h expected %h", o, 64'd0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (flags_now() !== 5'd0) $display("FAIL reset_flags: got %b expected 00000", flags_now()); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [63:0] r; logic [4:0] f; int lat, bc;
    run_op(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd0, 0, 0, r, f, lat, bc);
    total_cnt++; if (r !== 64'h4008_0000_0000_0000) $display("FAIL basic_o: got %h expected 4008000000000000", r); else pass_cnt++;
    total_cnt++; if (f !== 5'd0) $display("FAIL basic_flags: got %b expected 00000", f); else pass_cnt++;
    total_cnt++; if (lat !== 59) $display("FAIL basic_latency: got %0d expected 59", lat); else pass_cnt++;
    total_cnt++; if (bc !== 58) $display("FAIL basic_busy_cycles: got %0d expected 58", bc); else pass_cnt++;
  endtask

  task automatic test_rounding();
    logic [63:0] r; logic [4:0] f; int lat, bc;
    logic [63:0] exp_tab [5] = '{64'h3FD5_5555_5555_5555, 64'h3FD5_5555_5555_5555,
                                 64'h3FD5_5555_5555_5556, 64'h3FD5_5555_5555_5555,
                                 64'h3FD5_5555_5555_5555};
    for (int m = 0; m < 5; m++) begin
      run_op(64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 3'(m), 0, 0, r, f, lat, bc);
      total_cnt++;
      if (r !== exp_tab[m]) $display("FAIL third_rm%0d: got %h expected %h", m, r, exp_tab[m]); else pass_cnt++;
    end
  endtask

  task automatic test_special();
    logic [63:0] r; logic [4:0] f; int lat, bc;
    run_op(64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0000, 3'd0, 0, 0, r, f, lat, bc);
    total_cnt++; if (r !== 64'h7FF0_0000_0000_0000) $display("FAIL div_zero_o: got %h expected 7ff0000000000000", r); else pass_cnt++;
    total_cnt++; if (f !== 5'b10010) $display("FAIL div_zero_flags: got %b expected 10010", f); else pass_cnt++;
    run_op(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 3'd0, 0, 0, r, f, lat, bc);
    total_cnt++; if (r !== 64'h7FF8_0000_0000_0000) $display("FAIL zero_zero_o: got %h expected 7ff8000000000000", r); else pass_cnt++;
    total_cnt++; if (f !== 5'b00001) $display("FAIL zero_zero_flags: got %b expected 00001", f); else pass_cnt++;
    total_cnt++; if (lat !== 59) $display("FAIL special_latency: got %0d expected 59", lat); else pass_cnt++;
    run_op(64'hBFF0_0000_0000_0000, 64'h4010_0000_0000_0000, 3'd0, 0, 0, r, f, lat, bc);
    total_cnt++; if (r !== 64'hBFD0_0000_0000_0000) $display("FAIL neg_quarter_o: got %h expected bfd0000000000000", r); else pass_cnt++;
    total_cnt++; if (f !== 5'd0) $display("FAIL neg_quarter_flags: got %b expected 00000", f); else pass_cnt++;
    run_op(64'h7FF4_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'd0, 0, 0, r, f, lat, bc);
    total_cnt++; if (r !== 64'h7FFC_0000_0000_0000) $display("FAIL snan_o: got %h expected 7ffc000000000000", r); else pass_cnt++;
    total_cnt++; if (f !== 5'b00001) $display("FAIL snan_flags: got %b expected 00001", f); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [63:0] r; logic [4:0] f; int lat, bc;
    run_op(64'h7FEF_FFFF_FFFF_FFFF, 64'h3FE0_0000_0000_0000, 3'd0, 0, 0, r, f, lat, bc);
    total_cnt++; if (r !== 64'h7FF0_0000_0000_0000) $display("FAIL ovf_rne_o: got %h expected 7ff0000000000000", r); else pass_cnt++;
    total_cnt++; if (f !== 5'b11000) $display("FAIL ovf_rne_flags: got %b expected 11000", f); else pass_cnt++;
    run_op(64'h7FEF_FFFF_FFFF_FFFF, 64'h3FE0_0000_0000_0000, 3'd1, 0, 0, r, f, lat, bc);
    total_cnt++; if (r !== 64'h7FEF_FFFF_FFFF_FFFF) $display("FAIL ovf_rtz_o: got %h expected 7fefffffffffffff", r); else pass_cnt++;
    total_cnt++; if (f !== 5'b01000) $display("FAIL ovf_rtz_flags: got %b expected 01000", f); else pass_cnt++;
  endtask

  task automatic test_underflow();
    logic [63:0] r; logic [4:0] f; int lat, bc;
    run_op(64'h0010_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd0, 0, 0, r, f, lat, bc);
    total_cnt++; if (r !== 64'd0) $display("FAIL unf_o: got %h expected 0000000000000000", r); else pass_cnt++;
    total_cnt++; if (f !== 5'b00100) $display("FAIL unf_flags: got %b expected 00100", f); else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    logic [63:0] r; logic [4:0] f; int lat, bc;
    run_op(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd0, 10, 0, r, f, lat, bc);
    total_cnt++; if (r !== 64'h4008_0000_0000_0000) $display("FAIL busy_ld_o: got %h expected 4008000000000000", r); else pass_cnt++;
    total_cnt++; if (lat !== 59) $display("FAIL busy_ld_latency: got %0d expected 59", lat); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic seen = 1'b0;
    @(negedge clk);
    a = 64'h4018_0000_0000_0000; b = 64'h4000_0000_0000_0000; rm = 3'd0; ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (o !== 64'd0) $display("FAIL abort_o: got %h expected 0000000000000000", o); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", seen); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_idle_busy: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] r; logic [4:0] f; int lat, bc;
    run_op(64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000, 3'd0, 0, 0, r, f, lat, bc);
    total_cnt++; if (r !== 64'h3FD5_5555_5555_5555) $display("FAIL after_rst_o: got %h expected 3fd5555555555555", r); else pass_cnt++;
    total_cnt++; if (lat !== 59) $display("FAIL after_rst_latency: got %0d expected 59", lat); else pass_cnt++;
  endtask

  task automatic test_ce_stall();
    logic [63:0] r; logic [4:0] f; int lat, bc;
    run_op(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 3'd0, 0, 20, r, f, lat, bc);
    total_cnt++; if (r !== 64'h4008_0000_0000_0000) $display("FAIL ce_stall_o: got %h expected 4008000000000000", r); else pass_cnt++;
    total_cnt++; if (lat !== 64) $display("FAIL ce_stall_latency: got %0d expected 64", lat); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_overflow();
    test_underflow();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_ce_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fp_divide64_iter.md
Name: fp_divide64_iter

Overview:
- Iterative IEEE 754 binary64 divider: computes o = a / b, then normalizes and rounds the result in one block.
- Companion to the pipelined FP64 multiply-normalize-round path. Shares the FP64 operand format and the rm encoding with it.
- Start/done handshake. Accepts one operation at a time with fixed latency.
- Intended as the FDIV execution unit beside the multiplier.

Parameters:
- QBITS, 56, quotient bits developed: 1 integer + 52 fraction + guard + round + 1 extra. Sticky bit comes from the final remainder.
- LAT, 59, clocks from the ld-sampling edge to done (QBITS + 3).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- ce  input  1  clock enable; when low, all state and outputs freeze
- ld  input  1  start pulse; sampled only when idle
- a  input  64  dividend, FP64 (sign, exp[10:0], man[51:0])
- b  input  64  divisor, FP64
- rm  input  3  rounding mode: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf), 4 RMM; 5-7 behave as RNE
- o  output  64  result; held until the next ld is accepted
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; o and flags are valid from this cycle on
- inf  output  1  result is infinity
- overflow  output  1  exponent overflow
- underflow  output  1  result below the normal range, flushed to zero
- dbz  output  1  finite nonzero / zero
- invalid  output  1  0/0, inf/inf, or signalling-NaN operand

Behaviour:
- Reset: state IDLE; o=0, busy=0, done=0; all flags 0; quotient, remainder and counter cleared. Reset mid-operation aborts the operation: no done is issued.
- All counting below is in ce-high cycles.
- States: IDLE -> DIV -> NORM -> RND -> DONE -> IDLE.
- IDLE:
  - ld=1 latches a, b and rm.
  - Unpacks: hidden bit set for normal operands; denormal operands flushed to signed zero.
  - Computes sign = a.s ^ b.s and exponent e = ea - eb + 1023 (13-bit signed).
  - Classifies special cases. Sets busy=1 and moves to DIV.
- DIV:
  - Restoring radix-2, one quotient bit per cycle, MSB first, QBITS cycles.
  - Remainder width 55 bits. rem starts as the dividend mantissa. Each step: if rem >= divisor then q bit = 1 and rem -= divisor; then rem <<= 1.
  - Special-case operations still spend the full latency; the quotient is discarded.
- NORM:
  - If the integer quotient bit is 0: shift q left 1 and decrement e.
  - sticky = (rem != 0) OR any bit below round.
  - e >= 2047: overflow. e <= 0: underflow, result flushed to signed zero.
- RND:
  - Rounds using guard, round and sticky per rm.
  - Mantissa carry-out renormalizes (e+1), which may itself cause overflow.
  - Overflow result: RNE/RMM give infinity. RTZ gives max finite 0x7FEF_FFFF_FFFF_FFFF with the result sign. RUP gives +inf if positive, else -max finite. RDN is the mirror of RUP.
- DONE: drives o and flags, done=1 for exactly one cycle, busy=0, returns to IDLE.
- Special-case results:
  - NaN operand: result is a with the quiet bit set if a is NaN, otherwise b with the quiet bit set. invalid=1 if that operand is signalling.
  - 0/0 and inf/inf: 0x7FF8_0000_0000_0000, invalid=1.
  - x/0 (x finite nonzero): signed infinity, dbz=1, inf=1.
  - inf/x: signed infinity, inf=1.
  - 0/x and x/inf: signed zero.
- Flags are cleared when ld is accepted and updated together with o at done.
- ld while busy is ignored; no queueing.
- ld in the same cycle as done (state DONE) is ignored. A new operation is accepted in IDLE from the next cycle.
- ce low: counter does not advance, done stays at its current level. Latency extends by the number of ce-low cycles.

Test Plan:
- a=0x4018000000000000 (6.0), b=0x4000000000000000 (2.0), rm=0, ld pulse -> busy=1 for 58 clocks; done exactly 59 clocks later; o=0x4008000000000000; all flags 0.
- a=0x3FF0000000000000 (1.0), b=0x4008000000000000 (3.0) -> RNE and RTZ give 0x3FD5555555555555; RUP gives 0x3FD5555555555556; RDN gives 0x3FD5555555555555.
- 1.0/+0 -> o=0x7FF0000000000000, dbz=1, inf=1. 0/0 -> o=0x7FF8000000000000, invalid=1. -1.0/4.0 -> o=0xBFD0000000000000.
- a=0x7FEFFFFFFFFFFFFF, b=0x3FE0000000000000 (0.5) -> RNE gives 0x7FF0000000000000 with overflow=1 and inf=1; RTZ gives 0x7FEFFFFFFFFFFFFF with overflow=1.
- a=0x0010000000000000, b=0x4000000000000000 -> o=0x0000000000000000, underflow=1.
- Start 6.0/2.0; pulse ld with other operands at cycle 10 -> ignored, original result returned. Assert rst at cycle 30 -> busy=0, no done. New ld of 1.0/3.0 -> done 59 clocks later with the correct value. ce held low for 5 cycles mid-DIV -> done arrives at 64 clocks.
